// File: rtl/v_pkg.sv
// Shared widths, writeback entry layout and occupancy-width helper for the
// vector writeback path.
package v_pkg;

   localparam int V_VECTOR_WIDTH = 64;
   localparam int V_VECTOR_BYTE  = 8;
   localparam int V_ADDR_WITH    = 32;
   localparam int V_DEPTH        = 4;
   localparam int V_COUNT_W      = $clog2(V_DEPTH + 1);

   typedef struct packed {
      logic [V_VECTOR_WIDTH-1:0] vec;
      logic [V_ADDR_WITH-1:0]    addr;
      logic [V_VECTOR_BYTE-1:0]  byte_en;
   } wb_entry_t;

   // Occupancy must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/v_sync_fifo.sv
// Generic first-word-fall-through FIFO: head entry is visible on rdata while
// count is non-zero. Callers must only push when there is room (or a pop occurs
// in the same cycle) and only pop when non-empty.
module v_sync_fifo
   import v_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_next
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata      = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/v_wb_buffer.sv
// Writeback buffer between the vector add unit and the register-file write
// port: absorbs write-port stalls, hints issue when nearly full, flags drops.
module v_wb_buffer
   import v_pkg::*;
#(
   parameter int VECTOR_WIDTH = V_VECTOR_WIDTH,
   parameter int VECTOR_BYTE  = V_VECTOR_BYTE,
   parameter int ADDR_WITH    = V_ADDR_WITH,
   parameter int DEPTH        = V_DEPTH,
   parameter int AFULL_LEVEL  = 3,
   localparam int CW = count_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [VECTOR_WIDTH-1:0] in_vec,
   input  logic [ADDR_WITH-1:0]    in_addr,
   input  logic [VECTOR_BYTE-1:0]  in_byte_en,
   input  logic                    in_valid,
   output logic [VECTOR_WIDTH-1:0] wr_vec,
   output logic [ADDR_WITH-1:0]    wr_addr,
   output logic [VECTOR_BYTE-1:0]  wr_byte_en,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic                    afull,
   output logic [CW-1:0]           count,
   output logic                    overflow
);

   localparam int EW = VECTOR_WIDTH + ADDR_WITH + VECTOR_BYTE;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

   logic [EW-1:0] head;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] fifo_count_next;
   logic          push;
   logic          pop;
   logic          afull_q;
   logic          afull_d;
   logic          overflow_q;
   logic          overflow_d;

   assign wr_valid = (fifo_count != '0);
   assign pop      = wr_valid & wr_ready;
   // A full buffer still accepts a beat when the head leaves in the same cycle.
   assign push     = in_valid & ((fifo_count < DEPTH_C) | pop);

   v_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .wdata      ({in_vec, in_addr, in_byte_en}),
      .rdata      (head),
      .count      (fifo_count),
      .count_next (fifo_count_next)
   );

   always_comb begin
      afull_d    = (fifo_count_next >= AFULL_C);
      overflow_d = overflow_q | (in_valid & ~push);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         afull_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         afull_q    <= afull_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not cleared on reset, so an empty buffer presents zeros.
   assign {wr_vec, wr_addr, wr_byte_en} = wr_valid ? head : '0;
   assign count    = fifo_count;
   assign afull    = afull_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_v_wb_buffer.sv
// Self-checking bench for v_wb_buffer: a queue-based reference model tracks
// the expected contents, occupancy and sticky overflow.
module tb_v_wb_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [63:0] vec;
      logic [31:0] addr;
      logic [7:0]  be;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_vec;
   logic [31:0] in_addr;
   logic [7:0]  in_byte_en;
   logic        in_valid;
   logic [63:0] wr_vec;
   logic [31:0] wr_addr;
   logic [7:0]  wr_byte_en;
   logic        wr_valid;
   logic        wr_ready;
   logic        afull;
   logic [2:0]  count;
   logic        overflow;

   ent_t q[$];
   bit   m_ovf;
   int   errors = 0;
   int   checks = 0;

   v_wb_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .in_vec     (in_vec),
      .in_addr    (in_addr),
      .in_byte_en (in_byte_en),
      .in_valid   (in_valid),
      .wr_vec     (wr_vec),
      .wr_addr    (wr_addr),
      .wr_byte_en (wr_byte_en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .afull      (afull),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // One clock edge: the model applies the buffer's acceptance rules to the
   // inputs seen at that edge, then outputs are sampled 1 time unit later.
   task automatic tick();
      bit pop;
      bit push;
      ent_t e;
      @(posedge clk);
      pop  = (q.size() != 0) && wr_ready;
      push = in_valid && ((q.size() < DEPTH) || pop);
      e.vec = in_vec;
      e.addr = in_addr;
      e.be = in_byte_en;
      if (pop) q.delete(0);
      if (push) q.push_back(e);
      if (in_valid && !push) m_ovf = 1'b1;
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
      in_valid   = v;
      in_addr    = a;
      in_vec     = d;
      in_byte_en = be;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      wr_ready = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      wr_ready = 1'b0;
      #3;
      checks++;
      if ({wr_valid, count, afull, overflow} !== 6'b0) begin
         errors++;
         $display("FAIL reset_status: got valid=%0b count=%0d afull=%0b ovf=%0b, want all 0", wr_valid, count, afull, overflow);
      end
      checks++;
      if ({wr_vec, wr_addr, wr_byte_en} !== 104'h0) begin
         errors++;
         $display("FAIL reset_data: got vec=%h addr=%h be=%h, want 0", wr_vec, wr_addr, wr_byte_en);
      end
      apply_reset();
   endtask

   task automatic test_single_beat();
      wr_ready = 1'b1;
      drive(1'b1, 32'h10, 64'h1, 8'hFF);
      tick();
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (wr_valid !== 1'b1 || wr_vec !== 64'h1 || wr_addr !== 32'h10 || wr_byte_en !== 8'hFF) begin
         errors++;
         $display("FAIL single_head: got valid=%0b vec=%h addr=%h be=%h, want 1/1/10/ff", wr_valid, wr_vec, wr_addr, wr_byte_en);
      end
      checks++;
      if (count !== 3'd1) begin
         errors++;
         $display("FAIL single_count1: got %0d want 1", count);
      end
      tick();
      checks++;
      if (count !== 3'(q.size()) || wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drained: got count=%0d valid=%0b want 0/0", count, wr_valid);
      end
   endtask

   task automatic test_fill_stall();
      wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i), {$urandom, $urandom}, 8'($urandom));
         tick();
         checks++;
         if (count !== 3'(q.size()) || afull !== (q.size() >= 3) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_push%0d: got count=%0d afull=%0b ovf=%0b want %0d/%0b/0", i, count, afull, overflow, q.size(), q.size() >= 3);
         end
      end
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_valid !== 1'b1 || wr_addr !== 32'(i) || wr_vec !== q[0].vec || wr_byte_en !== q[0].be) begin
            errors++;
            $display("FAIL fill_drain%0d: got valid=%0b addr=%0d vec=%h want 1/%0d/%h", i, wr_valid, wr_addr, wr_vec, i, q[0].vec);
         end
         tick();
      end
      checks++;
      if (count !== 3'd0 || afull !== 1'b0) begin
         errors++;
         $display("FAIL fill_empty: got count=%0d afull=%0b want 0/0", count, afull);
      end
   endtask

   task automatic test_overflow();
      wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i), {$urandom, $urandom}, 8'($urandom));
         tick();
      end
      drive(1'b1, 32'd9, 64'hDEAD, 8'h0F);
      tick();
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (overflow !== m_ovf || overflow !== 1'b1 || count !== 3'd4) begin
         errors++;
         $display("FAIL ovf_set: got ovf=%0b count=%0d want 1/4", overflow, count);
      end
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_addr !== 32'(i)) begin
            errors++;
            $display("FAIL ovf_drain%0d: got addr=%0d want %0d", i, wr_addr, i);
         end
         tick();
      end
      tick();
      tick();
      checks++;
      if (overflow !== 1'b1 || wr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%0b valid=%0b want 1/0", overflow, wr_valid);
      end
   endtask

   task automatic test_full_push_pop();
      int exp_addr[4] = '{1, 2, 3, 7};
      apply_reset();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL fpp_ovf_cleared: got %0b want 0", overflow);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i), {$urandom, $urandom}, 8'($urandom));
         tick();
      end
      wr_ready = 1'b1;
      drive(1'b1, 32'd7, 64'h7777, 8'h00);
      tick();
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (count !== 3'd4 || overflow !== 1'b0 || afull !== 1'b1) begin
         errors++;
         $display("FAIL fpp_count: got count=%0d ovf=%0b afull=%0b want 4/0/1", count, overflow, afull);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_addr !== 32'(exp_addr[i]) || wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL fpp_order%0d: got addr=%0d valid=%0b want %0d/1", i, wr_addr, wr_valid, exp_addr[i]);
         end
         if (i == 3) begin
            checks++;
            if (wr_vec !== 64'h7777 || wr_byte_en !== 8'h00) begin
               errors++;
               $display("FAIL fpp_zero_be: got vec=%h be=%h want 7777/00", wr_vec, wr_byte_en);
            end
         end
         tick();
      end
   endtask

   task automatic test_stream();
      int sent = 0;
      int delivered = 0;
      int cyc = 0;
      bit hold;
      logic [103:0] held;
      apply_reset();
      while ((sent < 20 || q.size() != 0) && cyc < 300) begin
         wr_ready = (cyc % 2 == 0);
         if (sent < 20 && q.size() < 3 && $urandom_range(0, 3) != 0) begin
            drive(1'b1, 32'(100 + sent), {$urandom, $urandom}, 8'($urandom));
            sent++;
         end else begin
            drive(1'b0, 32'h0, 64'h0, 8'h0);
         end
         if (wr_valid && wr_ready) begin
            checks++;
            if (wr_addr !== 32'(100 + delivered) || wr_vec !== q[0].vec || wr_byte_en !== q[0].be) begin
               errors++;
               $display("FAIL stream_beat%0d: got addr=%0d vec=%h be=%h want %0d/%h/%h", delivered, wr_addr, wr_vec, wr_byte_en, 100 + delivered, q[0].vec, q[0].be);
            end
            delivered++;
         end
         hold = wr_valid && !wr_ready;
         held = {wr_vec, wr_addr, wr_byte_en};
         tick();
         if (hold) begin
            checks++;
            if ({wr_vec, wr_addr, wr_byte_en} !== held || wr_valid !== 1'b1) begin
               errors++;
               $display("FAIL stream_stable: got %h want %h", {wr_vec, wr_addr, wr_byte_en}, held);
            end
         end
         checks++;
         if (count !== 3'(q.size()) || wr_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL stream_count: got count=%0d valid=%0b want %0d", count, wr_valid, q.size());
         end
         cyc++;
      end
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (delivered != 20 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL stream_total: got delivered=%0d ovf=%0b want 20/0", delivered, overflow);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(40 + i), {$urandom, $urandom}, 8'hFF);
         tick();
      end
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (count !== 3'd3 || afull !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: got count=%0d afull=%0b want 3/1", count, afull);
      end
      wr_ready = 1'b1;
      #3;
      rst = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      #1;
      checks++;
      if (wr_valid !== 1'b0 || count !== 3'd0 || afull !== 1'b0) begin
         errors++;
         $display("FAIL arst_immediate: got valid=%0b count=%0d afull=%0b want 0/0/0", wr_valid, count, afull);
      end
      #2;
      rst = 1'b0;
      drive(1'b1, 32'd5, 64'h55, 8'h3C);
      tick();
      drive(1'b0, 32'h0, 64'h0, 8'h0);
      checks++;
      if (wr_valid !== 1'b1 || wr_addr !== 32'd5 || wr_vec !== 64'h55 || count !== 3'd1) begin
         errors++;
         $display("FAIL arst_first_beat: got valid=%0b addr=%0d vec=%h count=%0d want 1/5/55/1", wr_valid, wr_addr, wr_vec, count);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_fill_stall();
      test_overflow();
      test_full_push_pop();
      test_stream();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
